// File: rtl/wb_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pwm_pkg
// Description : Shared definitions for the Wishbone multi-channel PWM block:
//               register byte offsets, CTRL bit indices, legal parameter
//               ranges and a byte-lane merge helper for partial writes.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pwm_pkg;

    // Register byte offsets (only address bits [7:0] are decoded)
    localparam logic [7:0] c_REG_CTRL       = 8'h00;
    localparam logic [7:0] c_REG_CH_EN      = 8'h04;
    localparam logic [7:0] c_REG_IRQ_STATUS = 8'h08;
    localparam logic [7:0] c_REG_IRQ_MASK   = 8'h0C;
    localparam logic [7:0] c_REG_CH_BASE    = 8'h40;
    localparam int         c_CH_STRIDE      = 8;   // PERIOD/DUTY pair per channel
    localparam int         c_DUTY_OFS       = 4;   // DUTY sits after PERIOD

    // CTRL bit indices
    localparam int c_CTRL_EN_BIT = 0;

    // Legal parameter ranges
    localparam int c_NCH_MIN = 1;
    localparam int c_NCH_MAX = 16;
    localparam int c_CW_MIN  = 2;
    localparam int c_CW_MAX  = 32;

    // Replace the byte lanes of i_old selected by i_sel with those of i_new.
    function automatic logic [31:0] f_merge_sel(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_sel
    );
        logic [31:0] merged;
        merged = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_sel[b]) merged[8*b +: 8] = i_new[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ============================================================================
// Module      : pwm_chan
// Description : One PWM channel. Bus writes land in shadow PERIOD/DUTY
//               registers; the active copies reload from the shadows at every
//               period wrap, or continuously while the channel is disabled.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_en             - channel enable (global & per-channel)
//               i_per_we/i_duty_we, i_per_wdata/i_duty_wdata - shadow writes
//               o_per_sh/o_duty_sh - shadow values for bus readback
//               o_pwm            - registered PWM output
//               o_wrap           - combinational wrap event this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_chan
    import wb_pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_per_we,
    input  logic          i_duty_we,
    input  logic [CW-1:0] i_per_wdata,
    input  logic [CW-1:0] i_duty_wdata,
    output logic [CW-1:0] o_per_sh,
    output logic [CW-1:0] o_duty_sh,
    output logic          o_pwm,
    output logic          o_wrap
);

    logic [CW-1:0] r_per_sh;
    logic [CW-1:0] r_duty_sh;
    logic [CW-1:0] r_per_act;
    logic [CW-1:0] r_duty_act;
    logic [CW-1:0] r_cnt;
    logic          r_pwm;
    logic          w_last;

    // PERIOD of 0 or 1 degenerates to a one-state counter wrapping every cycle.
    assign w_last = (r_per_act <= CW'(1)) || (r_cnt >= r_per_act - CW'(1));
    assign o_wrap = i_en & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_sh   <= '0;
            r_duty_sh  <= '0;
            r_per_act  <= '0;
            r_duty_act <= '0;
            r_cnt      <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (i_per_we)  r_per_sh  <= i_per_wdata;
            if (i_duty_we) r_duty_sh <= i_duty_wdata;

            if (!i_en) begin
                r_cnt      <= '0;
                r_per_act  <= r_per_sh;
                r_duty_act <= r_duty_sh;
                r_pwm      <= 1'b0;
            end else begin
                r_pwm <= (r_cnt < r_duty_act);
                if (w_last) begin
                    // Reload from the pre-write shadow: a same-cycle bus
                    // write only takes effect at the following wrap.
                    r_cnt      <= '0;
                    r_per_act  <= r_per_sh;
                    r_duty_act <= r_duty_sh;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_per_sh  = r_per_sh;
    assign o_duty_sh = r_duty_sh;
    assign o_pwm     = r_pwm;

endmodule
`default_nettype wire

// File: rtl/wb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : wb_pwm_multi
// Description : Wishbone classic slave with NCH independent PWM channels.
//               Holds bus decode, CTRL/CH_EN and optional IRQ registers.
// Ports       : clk, rst (sync, active-high); wb_* Wishbone classic slave;
//               pwm_o[NCH] registered PWM outputs; irq_o period-wrap irq.
// Config      : define WB_PWM_MULTI_IRQ_EN to build IRQ_STATUS/IRQ_MASK and
//               drive irq_o; otherwise those registers read 0 and irq_o = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pwm_multi
    import wb_pwm_pkg::*;
#(
    parameter int NCH          = 8,
    parameter int CW           = 16,
    parameter int wb_adr_width = 32,
    parameter int wb_dat_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [wb_adr_width-1:0] wb_adr_i,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    output logic [wb_dat_width-1:0] wb_dat_o,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [3:0]              wb_sel_i,
    output logic                    wb_ack_o,
    output logic [NCH-1:0]          pwm_o,
    output logic                    irq_o
);

    if (NCH < c_NCH_MIN || NCH > c_NCH_MAX || CW < c_CW_MIN || CW > c_CW_MAX ||
        wb_dat_width != 32 || wb_adr_width < 9) begin : g_bad_params
        $error("wb_pwm_multi: parameter out of legal range");
    end

    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_ctrl_en;
    logic [NCH-1:0]  r_ch_en;
    logic            w_req;
    logic            w_wr;
    logic [7:0]      w_adr;
    logic [31:0]     w_rdata;
    logic [31:0]     w_chen_merge;
    logic [NCH-1:0]  w_en;
    logic [NCH-1:0]  w_wrap;
    logic [NCH-1:0]  w_pwm;
    logic [CW-1:0]   w_per_sh  [NCH];
    logic [CW-1:0]   w_duty_sh [NCH];
    logic            w_unused;

    // A request is accepted only while ack is low, so ack never repeats.
    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr         = w_req & wb_we_i;
    assign w_adr        = wb_adr_i[7:0];
    assign w_en         = {NCH{r_ctrl_en}} & r_ch_en;
    assign w_chen_merge = f_merge_sel(32'(r_ch_en), wb_dat_i, wb_sel_i);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [31:0] w_per_merge;
        logic [31:0] w_duty_merge;
        logic        w_per_we;
        logic        w_duty_we;
        logic        w_unused_merge;

        assign w_per_we     = w_wr && (w_adr == 8'(c_REG_CH_BASE + c_CH_STRIDE*i));
        assign w_duty_we    = w_wr && (w_adr == 8'(c_REG_CH_BASE + c_CH_STRIDE*i + c_DUTY_OFS));
        assign w_per_merge  = f_merge_sel(32'(w_per_sh[i]),  wb_dat_i, wb_sel_i);
        assign w_duty_merge = f_merge_sel(32'(w_duty_sh[i]), wb_dat_i, wb_sel_i);
        assign w_unused_merge = &{1'b0, w_per_merge, w_duty_merge};

        pwm_chan #(.CW(CW)) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_en         (w_en[i]),
            .i_per_we     (w_per_we),
            .i_duty_we    (w_duty_we),
            .i_per_wdata  (w_per_merge[CW-1:0]),
            .i_duty_wdata (w_duty_merge[CW-1:0]),
            .o_per_sh     (w_per_sh[i]),
            .o_duty_sh    (w_duty_sh[i]),
            .o_pwm        (w_pwm[i]),
            .o_wrap       (w_wrap[i])
        );
    end

`ifdef WB_PWM_MULTI_IRQ_EN
    logic [NCH-1:0] r_irq_st;
    logic [NCH-1:0] r_irq_mask;
    logic           r_irq;
    logic [31:0]    w_clr_merge;
    logic [31:0]    w_mask_merge;
    logic [NCH-1:0] w_clr;

    assign w_clr_merge  = f_merge_sel(32'h0, wb_dat_i, wb_sel_i);
    assign w_mask_merge = f_merge_sel(32'(r_irq_mask), wb_dat_i, wb_sel_i);
    assign w_clr        = (w_wr && w_adr == c_REG_IRQ_STATUS) ? w_clr_merge[NCH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_st   <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            // Write-1-to-clear; a wrap in the same cycle keeps the bit set.
            r_irq_st <= (r_irq_st & ~w_clr) | w_wrap;
            if (w_wr && w_adr == c_REG_IRQ_MASK) r_irq_mask <= w_mask_merge[NCH-1:0];
            r_irq <= |(r_irq_st & r_irq_mask);
        end
    end

    assign irq_o    = r_irq;
    assign w_unused = &{1'b0, wb_adr_i[wb_adr_width-1:8], w_chen_merge, w_clr_merge, w_mask_merge};
`else
    assign irq_o    = 1'b0;
    assign w_unused = &{1'b0, wb_adr_i[wb_adr_width-1:8], w_chen_merge, w_wrap};
`endif

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            c_REG_CTRL:       w_rdata[c_CTRL_EN_BIT] = r_ctrl_en;
            c_REG_CH_EN:      w_rdata = 32'(r_ch_en);
`ifdef WB_PWM_MULTI_IRQ_EN
            c_REG_IRQ_STATUS: w_rdata = 32'(r_irq_st);
            c_REG_IRQ_MASK:   w_rdata = 32'(r_irq_mask);
`endif
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_adr == 8'(c_REG_CH_BASE + c_CH_STRIDE*i))
                        w_rdata = 32'(w_per_sh[i]);
                    if (w_adr == 8'(c_REG_CH_BASE + c_CH_STRIDE*i + c_DUTY_OFS))
                        w_rdata = 32'(w_duty_sh[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_ctrl_en <= 1'b0;
            r_ch_en   <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rdata;
            if (w_wr && w_adr == c_REG_CTRL && wb_sel_i[0])
                r_ctrl_en <= wb_dat_i[c_CTRL_EN_BIT];
            if (w_wr && w_adr == c_REG_CH_EN)
                r_ch_en <= w_chen_merge[NCH-1:0];
        end
    end

    // Ack is qualified by the live strobe so an aborted cycle sees no ack.
    assign wb_ack_o = r_ack & wb_cyc_i & wb_stb_i;
    assign wb_dat_o = r_dat;
    assign pwm_o    = w_pwm;

endmodule
`default_nettype wire

// File: tb/tb_wb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_pwm_multi
// Description : Self-checking bench for wb_pwm_multi (NCH=8, CW=16):
//               register table, directed PWM/IRQ/reset sequences and a
//               randomized phase checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pwm_multi;

    localparam int NCH = 8;
    localparam int CW  = 16;
`ifdef WB_PWM_MULTI_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    wb_adr_i = '0;
    logic [31:0]    wb_dat_i = '0;
    logic [31:0]    wb_dat_o;
    logic           wb_we_i  = 1'b0;
    logic           wb_cyc_i = 1'b0;
    logic           wb_stb_i = 1'b0;
    logic [3:0]     wb_sel_i = '0;
    logic           wb_ack_o;
    logic [NCH-1:0] pwm_o;
    logic           irq_o;

    always #5 clk = ~clk;

    wb_pwm_multi #(.NCH(NCH), .CW(CW), .wb_adr_width(32), .wb_dat_width(32)) dut (
        .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .pwm_o(pwm_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Registers kept as a word-indexed map; each word holds only its
    // implemented bits. Channels are modelled as "position within period".
    logic [31:0]    m_reg [64];
    logic [NCH-1:0] m_st;
    int             m_pos  [NCH];
    int             m_plen [NCH];
    int             m_high [NCH];
    logic [NCH-1:0] m_pwm;
    logic           m_irq;
    logic           m_ack;
    logic [31:0]    m_rdata;

    function automatic logic [31:0] impl_mask(input int w);
        if (w == 0) return 32'h1;
        if (w == 1) return 32'((1 << NCH) - 1);
        if (w == 3) return IRQ_BUILD ? 32'((1 << NCH) - 1) : 32'h0;
        if (w >= 16 && w < 16 + 2*NCH) return 32'((1 << CW) - 1);
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        if (a[1:0] != 2'b00) return 32'h0;
        if (w == 2) return IRQ_BUILD ? 32'(m_st) : 32'h0;
        return m_reg[w];
    endfunction

    always @(posedge clk) begin : model
        logic [NCH-1:0] wraps;
        logic [31:0]    clr;
        int             w;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_reg[i] = '0;
            for (int n = 0; n < NCH; n++) begin
                m_pos[n] = 0; m_plen[n] = 0; m_high[n] = 0;
            end
            m_st = '0; m_pwm = '0; m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0;
        end else begin
            wraps = '0;
            clr   = '0;
            for (int n = 0; n < NCH; n++) begin
                if (!(m_reg[0][0] && m_reg[1][n])) begin
                    m_pos[n]  = 0;
                    m_plen[n] = int'(m_reg[16 + 2*n]);
                    m_high[n] = int'(m_reg[17 + 2*n]);
                    m_pwm[n]  = 1'b0;
                end else begin
                    m_pwm[n] = (m_pos[n] < m_high[n]);
                    if (m_pos[n] + 1 >= m_plen[n]) begin
                        wraps[n]  = 1'b1;
                        m_pos[n]  = 0;
                        m_plen[n] = int'(m_reg[16 + 2*n]);
                        m_high[n] = int'(m_reg[17 + 2*n]);
                    end else begin
                        m_pos[n] = m_pos[n] + 1;
                    end
                end
            end
            m_irq = IRQ_BUILD && (|(m_st & m_reg[3][NCH-1:0]));
            if (wb_cyc_i && wb_stb_i && !m_ack) begin
                m_ack   = 1'b1;
                m_rdata = model_read(wb_adr_i[7:0]);
                if (wb_we_i && wb_adr_i[1:0] == 2'b00) begin
                    w = int'(wb_adr_i[7:2]);
                    if (w == 2) clr = merge(32'h0, wb_dat_i, wb_sel_i);
                    else m_reg[w] = merge(m_reg[w], wb_dat_i, wb_sel_i) & impl_mask(w);
                end
            end else begin
                m_ack = 1'b0;
            end
            m_st = IRQ_BUILD ? ((m_st & ~clr[NCH-1:0]) | wraps) : '0;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_pwm", 32'(pwm_o), 32'(m_pwm));
            check("mon_irq", 32'(irq_o), 32'(m_irq));
            check("mon_ack", 32'(wb_ack_o), 32'(m_ack & wb_cyc_i & wb_stb_i));
        end
    end

    // High-run lengths and rise times of channel 0.
    int   cyc_n = 0;
    int   run_len = 0;
    int   runs[$];
    int   rises[$];
    logic prev0 = 1'b0;
    always @(negedge clk) begin
        cyc_n++;
        if (pwm_o[0] === 1'b1) begin
            if (prev0 !== 1'b1) rises.push_back(cyc_n);
            run_len++;
        end else begin
            if (prev0 === 1'b1) runs.push_back(run_len);
            run_len = 0;
        end
        prev0 = pwm_o[0];
    end

    // ---------------- bus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic bus(input bit we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 'x;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {24'h0, adr}; wb_dat_i = dat; wb_sel_i = sel;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1) begin
                got = 1'b1;
                rd  = wb_dat_o;
            end
        end
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("ack_seen", 32'(got), 32'h1);
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        bus(1'b1, adr, dat, 4'hF, rd);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b0, adr, 32'h0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic wait_pwm0(input logic v, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (pwm_o[0] === v) ok = 1'b1;
        end
        #1;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          we;
        bit          ok;
        bit          got;
        int          ch;

        vecs[0] = '{"duty0_sel0", 8'h44, 32'h0000_ABCD, 4'b0001, 32'h0000_00CD};
        vecs[1] = '{"ch_en",      8'h04, 32'hFFFF_FF5A, 4'b1111, 32'h0000_005A};
        vecs[2] = '{"period0",    8'h40, 32'h1234_5678, 4'b1111, 32'h0000_5678};
        vecs[3] = '{"period1_b1", 8'h48, 32'h0000_FFFF, 4'b0010, 32'h0000_FF00};
        vecs[4] = '{"unmap_3c",   8'h3C, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[5] = '{"duty7",      8'h7C, 32'h0000_1234, 4'b0011, 32'h0000_1234};
        vecs[6] = '{"unmap_80",   8'h80, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[7] = '{"irq_status", 8'h08, 32'h0000_0001, 4'b1111, 32'h0000_0000};
        vecs[8] = '{"irq_mask",   8'h0C, 32'h0000_00FF, 4'b1111, IRQ_BUILD ? 32'h0000_00FF : 32'h0};
        vecs[9] = '{"ctrl",       8'h00, 32'h0000_0000, 4'b1111, 32'h0000_0000};

        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("rst_pwm",  32'(pwm_o), 32'h0);
        check("rst_ack",  32'(wb_ack_o), 32'h0);
        check("rst_irq",  32'(irq_o), 32'h0);
        check("rst_dat",  wb_dat_o, 32'h0);
        #1 rst = 1'b0;

        rd_chk("rst_ctrl_rd", 8'h00, 32'h0);
        for (int i = 0; i < 10; i++) begin
            bus(1'b1, vecs[i].adr, vecs[i].wdat, vecs[i].sel, rd);
            bus(1'b0, vecs[i].adr, 32'h0, 4'hF, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // Basic 3-of-10 waveform
        do_reset();
        wr(8'h40, 10); wr(8'h44, 3); wr(8'h04, 1); wr(8'h00, 1);
        runs.delete(); rises.delete();
        idle(40);
        check("A_nruns", 32'(runs.size() >= 3 && rises.size() >= 3), 32'h1);
        if (runs.size() >= 3 && rises.size() >= 3) begin
            check("A_high_len",  32'(runs[1]), 32'd3);
            check("A_high_len2", 32'(runs[2]), 32'd3);
            check("A_period",    32'(rises[2] - rises[1]), 32'd10);
        end

        // Mid-period duty change only takes effect next period
        wait_pwm0(1'b0, ok); check("B_wait_low", 32'(ok), 32'h1);
        wait_pwm0(1'b1, ok); check("B_wait_high", 32'(ok), 32'h1);
        runs.delete();
        wr(8'h44, 7);
        idle(25);
        check("B_nruns", 32'(runs.size() >= 2), 32'h1);
        if (runs.size() >= 2) begin
            check("B_cur_period", 32'(runs[0]), 32'd3);
            check("B_next_period", 32'(runs[1]), 32'd7);
        end

        // Duty 0 and duty > period
        wr(8'h50, 10); wr(8'h54, 0); wr(8'h58, 10); wr(8'h5C, 20); wr(8'h04, 32'h0D);
        idle(3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("C_pwm2_zero", 32'(pwm_o[2]), 32'h0);
            check("C_pwm3_one",  32'(pwm_o[3]), 32'h1);
        end
        #1;

        // Period-wrap interrupt
        do_reset();
        wr(8'h0C, 1); wr(8'h40, 5); wr(8'h04, 1); wr(8'h00, 1);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (irq_o === 1'b1) got = 1'b1;
        end
        #1;
        check("D_irq_rise", 32'(got), 32'(IRQ_BUILD));
        wr(8'h00, 0);
        idle(3);
        check("D_irq_held", 32'(irq_o), 32'(IRQ_BUILD));
        wr(8'h08, 1);
        idle(3);
        check("D_irq_clr", 32'(irq_o), 32'h0);

        // Reset during running PWM with a pending read
        wr(8'h40, 10); wr(8'h44, 3); wr(8'h0C, 1); wr(8'h00, 1);
        idle(4);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h40; wb_sel_i = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        check("E_pwm", 32'(pwm_o), 32'h0);
        check("E_ack", 32'(wb_ack_o), 32'h0);
        check("E_dat", wb_dat_o, 32'h0);
        check("E_irq", 32'(irq_o), 32'h0);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst = 1'b0;
        rd_chk("E_ctrl", 8'h00, 32'h0);
        rd_chk("E_chen", 8'h04, 32'h0);
        rd_chk("E_st",   8'h08, 32'h0);
        rd_chk("E_mask", 8'h0C, 32'h0);
        rd_chk("E_per0", 8'h40, 32'h0);
        rd_chk("E_dut0", 8'h44, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 300; it++) begin
            we  = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case ($urandom_range(0, 5))
                0: begin adr = 8'h00; dat = ($urandom_range(0, 9) < 8) ? 32'h1 : 32'h0; end
                1: begin adr = 8'h04; dat = $urandom; end
                2: begin adr = ($urandom_range(0, 1) == 1) ? 8'h08 : 8'h0C; dat = $urandom; end
                5: begin adr = 8'(8'h10 + 4*$urandom_range(0, 11)); dat = $urandom; end
                default: begin
                    ch  = int'($urandom_range(0, NCH-1));
                    adr = 8'(8'h40 + 8*ch + 4*$urandom_range(0, 1));
                    dat = 32'($urandom_range(0, 14));
                end
            endcase
            bus(we, adr, dat, sel, rd);
            if (!we) check("rand_rd", rd, m_rdata);
            idle(int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_pwm_multi.md
WB_PWM_MULTI -- requirements
Module: wb_pwm_multi

Interface
REQ-001 Parameter NCH, 8, number of PWM channels, legal range 1..16.
REQ-002 Parameter CW, 16, per-channel counter/period/duty width, legal range 2..32.
REQ-003 Parameter wb_adr_width, 32, Wishbone address width.
REQ-004 Parameter wb_dat_width, 32, Wishbone data width (fixed 32).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wb_adr_i  in  wb_adr_width  byte address; only [7:0] decoded.
REQ-008 wb_dat_i  in  32  write data.
REQ-009 wb_dat_o  out  32  read data, registered.
REQ-010 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone classic controls.
REQ-011 wb_sel_i  in  4  byte enables, honoured on writes.
REQ-012 wb_ack_o  out  1  transfer acknowledge.
REQ-013 pwm_o  out  NCH  PWM outputs, bit n = channel n, registered.
REQ-014 irq_o  out  1  period-wrap interrupt, level.

Function
REQ-015 Map: 0x00 CTRL (bit0 global enable), 0x04 CH_EN[NCH-1:0], 0x08 IRQ_STATUS, 0x0C IRQ_MASK, 0x40+8n PERIOD[n], 0x44+8n DUTY[n].
REQ-016 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored; still acked.
REQ-017 wb_ack_o SHALL assert the cycle after stb&cyc is seen with ack low, for exactly one cycle, gated by stb&cyc; no ack on consecutive cycles.
REQ-018 Written PERIOD/DUTY SHALL land in shadow registers; active copies SHALL load from shadows only at channel wrap, or continuously while channel disabled.
REQ-019 Reads of PERIOD/DUTY SHALL return shadow values, zero-extended from CW bits.
REQ-020 Channel n enabled = CTRL[0] & CH_EN[n]; disabled: counter held 0, pwm_o[n] = 0.
REQ-021 Enabled: counter counts 0..PERIOD_act-1, then wraps to 0 (wrap event) and active registers reload.
REQ-022 pwm_o[n] SHALL be 1 when counter < DUTY_act, registered, one clock after the counter value.
REQ-023 DUTY_act = 0: output constantly 0; DUTY_act >= PERIOD_act: constantly 1.
REQ-024 PERIOD_act = 0 or 1: counter stays 0, wrap event every cycle; output per REQ-023.
REQ-025 Counter SHALL never exceed 2^CW-1; no overflow path exists since PERIOD is CW bits.
REQ-026 Write to a shadow in the same cycle as wrap: active gets the old shadow; new value takes effect at next wrap.
REQ-027 Enable 0->1: first period uses latest shadows, counter starts at 0.

Reset
REQ-028 On rst: CTRL, CH_EN, IRQ_STATUS, IRQ_MASK, all shadow/active regs, counters = 0; pwm_o = 0; wb_dat_o = 0; ack = 0; irq_o = 0.
REQ-029 rst mid-transfer SHALL drop any pending ack; master retries.

Configuration
REQ-030 Macro WB_PWM_MULTI_IRQ_EN defined: IRQ_STATUS[n] set on channel n wrap, cleared by writing 1 (set wins on same cycle); irq_o = |(IRQ_STATUS & IRQ_MASK), registered.
REQ-031 Macro undefined: no status/mask storage; 0x08/0x0C read 0, writes ignored; irq_o tied 0.

Structure
REQ-032 Shared package wb_pwm_pkg SHALL hold register offsets, CTRL bit indices, and NCH/CW range constants.
REQ-033 Sub-module pwm_chan (one per channel, generate loop): shadows, active regs, counter, compare, wrap flag; wb_pwm_multi holds bus decode, global regs, IRQ.

Verification
REQ-034 NCH=8, CW=16; PERIOD[0]=10, DUTY[0]=3, CH_EN=1, CTRL=1 -> pwm_o[0] high 3, low 7 cycles, repeating.
REQ-035 Mid-period write DUTY[0]=7 -> current period keeps 3-high, next period 7-high.
REQ-036 DUTY[2]=0 and DUTY[3]=20 with PERIOD=10 -> pwm_o[2] constant 0, pwm_o[3] constant 1.
REQ-037 IRQ_EN build, IRQ_MASK=0x01, PERIOD[0]=5 -> irq_o rises within 6 cycles of enable; write 0x01 to 0x08 clears; without macro irq_o stays 0.
REQ-038 Read 0x44 after write 0xABCD with wb_sel_i=4'b0001 -> returns 0x00CD; read 0x3C -> 0; every access gets exactly one ack.
REQ-039 Assert rst during running PWM and pending read -> next cycle pwm_o=0, ack=0, all registers read 0.
